// File: rtl/ahb_cmd_issuer.sv
// Command front-end for the AHB subsystem top: buffers host commands in a FIFO,
// issues them one at a time and returns a single-cycle response per command.
module ahb_cmd_issuer #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int SLAVE_NUM      = 4,
   parameter int HBURST_WIDTH   = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int GUARD_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                              HCLK,
   input  logic                              HRST,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [$clog2(SLAVE_NUM)-1:0]      cmd_sel,
   input  logic [ADDR_WIDTH-1:0]             cmd_addr,
   input  logic [2:0]                        cmd_size,
   input  logic [HBURST_WIDTH-1:0]           cmd_burst,
   input  logic [DATA_WIDTH-1:0]             cmd_wdata,
   output logic                              bus_enable,
   output logic [DATA_WIDTH-1:0]             bus_wdata,
   output logic [ADDR_WIDTH-1:0]             bus_addr,
   output logic [$clog2(SLAVE_NUM)-1:0]      bus_sel,
   output logic [2:0]                        bus_size,
   output logic                              bus_write,
   output logic [HBURST_WIDTH-1:0]           bus_burst,
   input  logic [DATA_WIDTH-1:0]             bus_rdata,
   input  logic                              bus_ready,
   input  logic                              bus_resp,
   output logic                              rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic                              rsp_error,
   output logic                              rsp_timeout,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic                              busy
);

   localparam int SEL_W  = $clog2(SLAVE_NUM);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WCNT_W-1:0] GUARD_LIM = WCNT_W'(GUARD_CYCLES);
   localparam logic [WCNT_W-1:0] TMO_LAST  = WCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic                    write;
      logic [SEL_W-1:0]        sel;
      logic [ADDR_WIDTH-1:0]   addr;
      logic [2:0]              size;
      logic [HBURST_WIDTH-1:0] burst;
      logic [DATA_WIDTH-1:0]   wdata;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e                state_q, state_d;
   cmd_t                  mem_q [FIFO_DEPTH];
   cmd_t                  cmd_in;
   cmd_t                  hold_q, hold_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d, tmo_q, tmo_d;
   logic                  push, pop, fifo_empty, done, expired;

   assign cmd_in.write = cmd_write;
   assign cmd_in.sel   = cmd_sel;
   assign cmd_in.addr  = cmd_addr;
   assign cmd_in.size  = cmd_size;
   assign cmd_in.burst = cmd_burst;
   assign cmd_in.wdata = cmd_wdata;

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign cmd_ready  = (count_q < FULL_CNT);
   assign push       = cmd_valid && cmd_ready;
   assign fifo_empty = (count_q == '0);

   // State register
   always_ff @(posedge HCLK or posedge HRST) begin
      if (HRST) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (done || expired) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus_enable = 1'b0;
      rsp_valid  = 1'b0;
      pop        = 1'b0;
      done       = 1'b0;
      expired    = 1'b0;
      case (state_q)
         S_IDLE:  pop = !fifo_empty;
         S_ISSUE: bus_enable = 1'b1;
         S_WAIT: begin
            done    = bus_ready && (wcnt_q >= GUARD_LIM);
            expired = !done && (wcnt_q == TMO_LAST);
         end
         S_RESP:  rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: FIFO pointers, holding register, wait counter, response capture
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hold_d   = hold_q;
      wcnt_d   = wcnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      tmo_d    = tmo_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         hold_d   = mem_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (state_q == S_ISSUE) begin
         wcnt_d = '0;
      end else if (state_q == S_WAIT && !done && !expired) begin
         wcnt_d = wcnt_q + WCNT_W'(1);
      end

      if (done) begin
         rdata_d = hold_q.write ? '0 : bus_rdata;
         err_d   = bus_resp;
         tmo_d   = 1'b0;
      end else if (expired) begin
         rdata_d = '0;
         err_d   = 1'b0;
         tmo_d   = 1'b1;
      end
   end

   always_ff @(posedge HCLK or posedge HRST) begin
      if (HRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
         wcnt_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
         wcnt_q   <= wcnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   // NOTE: FIFO storage has no reset; an entry is only read after it has been written, so the pointers and count guard it.
   always_ff @(posedge HCLK) begin
      if (push) mem_q[wr_ptr_q] <= cmd_in;
   end

   assign bus_wdata   = hold_q.wdata;
   assign bus_addr    = hold_q.addr;
   assign bus_sel     = hold_q.sel;
   assign bus_size    = hold_q.size;
   assign bus_write   = hold_q.write;
   assign bus_burst   = hold_q.burst;
   assign rsp_rdata   = rdata_q;
   assign rsp_error   = err_q;
   assign rsp_timeout = tmo_q;
   assign fifo_count  = count_q;
   assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ahb_cmd_issuer.sv
// Scoreboard bench for ahb_cmd_issuer: directed commands push expected responses,
// an independent monitor pops and compares on every rsp_valid pulse.
module tb_ahb_cmd_issuer;

   logic        HCLK = 1'b0;
   logic        HRST;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_sel;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size, cmd_burst;
   logic        bus_enable, bus_write;
   logic [31:0] bus_wdata, bus_addr;
   logic [1:0]  bus_sel;
   logic [2:0]  bus_size, bus_burst;
   logic [31:0] bus_rdata;
   logic        bus_ready, bus_resp;
   logic        rsp_valid, rsp_error, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [2:0]  fifo_count;
   logic        busy;

   ahb_cmd_issuer dut (
      .HCLK(HCLK), .HRST(HRST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
      .cmd_burst(cmd_burst), .cmd_wdata(cmd_wdata),
      .bus_enable(bus_enable), .bus_wdata(bus_wdata), .bus_addr(bus_addr),
      .bus_sel(bus_sel), .bus_size(bus_size), .bus_write(bus_write),
      .bus_burst(bus_burst), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .bus_resp(bus_resp), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .fifo_count(fifo_count), .busy(busy)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] slave_mem [logic [33:0]];
   int          tests = 0, fails = 0;
   int          cyc = 0, rsp_seen = 0, en_cnt = 0;
   int          issue_cyc = 0, last_lat = 0, last_rsp_cyc = 0, accept_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge HCLK) cyc <= cyc + 1;

   // Downstream model: remembers writes, returns stored data for reads.
   always @(negedge HCLK) begin
      if (!HRST && bus_enable) begin
         en_cnt++;
         issue_cyc = cyc;
         if (bus_write) slave_mem[{bus_sel, bus_addr}] = bus_wdata;
         else bus_rdata = slave_mem.exists({bus_sel, bus_addr}) ? slave_mem[{bus_sel, bus_addr}] : 32'h0;
      end
   end

   // Response monitor
   always @(negedge HCLK) begin
      if (!HRST && rsp_valid) begin
         exp_t e;
         rsp_seen++;
         last_lat     = cyc - issue_cyc;
         last_rsp_cyc = cyc;
         check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_error", 64'(rsp_error), 64'(e.err));
            check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
         end
      end
   end

   task automatic push_cmd(input logic w, input logic [1:0] sel, input logic [31:0] addr,
                           input logic [2:0] size, input logic [2:0] burst, input logic [31:0] wdata,
                           input logic [31:0] e_rdata, input logic e_err, input logic e_tmo);
      int n = 0;
      exp_t e;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_sel   = sel;
      cmd_addr  = addr;
      cmd_size  = size;
      cmd_burst = burst;
      cmd_wdata = wdata;
      while (!cmd_ready && n < 300) begin
         @(posedge HCLK); #1;
         n++;
      end
      check("push_accept_bound", 64'(cmd_ready), 64'd1);
      if (cmd_ready) begin
         @(posedge HCLK); #1;
         accept_cyc = cyc;
         e.rdata = e_rdata;
         e.err   = e_err;
         e.tmo   = e_tmo;
         exp_q.push_back(e);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int n = 0;
      while (rsp_seen < target && n < 300) begin
         @(posedge HCLK); #1;
         n++;
      end
      check("rsp_wait_bound", 64'(rsp_seen >= target), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, en0, n;
      HRST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = '0; cmd_addr = '0;
      cmd_size = '0; cmd_burst = '0; cmd_wdata = '0; bus_rdata = '0;
      bus_ready = 1'b1; bus_resp = 1'b0;
      repeat (3) @(posedge HCLK);
      #1 HRST = 1'b0;
      @(posedge HCLK); #1;

      // Reset state
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_fifo_count", 64'(fifo_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bus_enable", 64'(bus_enable), 64'd0);
      check("rst_bus_addr", 64'(bus_addr), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);

      // Single write with minimum latency
      en0 = en_cnt;
      push_cmd(1'b1, 2'd2, 32'h10, 3'd2, 3'd0, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0);
      repeat (3) @(posedge HCLK);
      #1;
      check("t1_bus_sel", 64'(bus_sel), 64'd2);
      check("t1_bus_addr", 64'(bus_addr), 64'h10);
      check("t1_bus_wdata", 64'(bus_wdata), 64'hA5A5_0001);
      check("t1_bus_write", 64'(bus_write), 64'd1);
      check("t1_bus_size", 64'(bus_size), 64'd2);
      check("t1_busy", 64'(busy), 64'd1);
      wait_rsp(1);
      check("t1_push_to_rsp", 64'(last_rsp_cyc - accept_cyc), 64'd5);
      check("t1_issue_to_rsp", 64'(last_lat), 64'd4);
      check("t1_enable_pulses", 64'(en_cnt - en0), 64'd1);

      // Write then read back the same location
      push_cmd(1'b1, 2'd1, 32'h4, 3'd2, 3'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      push_cmd(1'b0, 2'd1, 32'h4, 3'd2, 3'd0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      wait_rsp(3);

      // FIFO full with the bus stalled
      base = rsp_seen;
      bus_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_cmd(1'b1, 2'd0, 32'h100 + 32'(i * 4), 3'd1, 3'd1, 32'h1000 + 32'(i), 32'h0, 1'b0, 1'b0);
      check("t3_count_full", 64'(fifo_count), 64'd4);
      check("t3_ready_low", 64'(cmd_ready), 64'd0);
      check("t3_bus_addr", 64'(bus_addr), 64'h100);
      check("t3_bus_burst", 64'(bus_burst), 64'd1);
      repeat (3) @(posedge HCLK);
      #1;
      check("t3_ready_stalled", 64'(cmd_ready), 64'd0);
      check("t3_count_stalled", 64'(fifo_count), 64'd4);
      bus_ready = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge HCLK); #1;
         n++;
      end
      check("t3_count_after_pop", 64'(fifo_count), 64'd3);
      check("t3_first_responded", 64'(rsp_seen - base), 64'd1);
      push_cmd(1'b1, 2'd0, 32'h200, 3'd1, 3'd1, 32'h2000, 32'h0, 1'b0, 1'b0);
      wait_rsp(base + 6);

      // Timeout, then the queued command completes normally
      base = rsp_seen;
      bus_ready = 1'b0;
      push_cmd(1'b0, 2'd1, 32'h4, 3'd2, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      push_cmd(1'b1, 2'd3, 32'h20, 3'd2, 3'd0, 32'h3333_0000, 32'h0, 1'b0, 1'b0);
      wait_rsp(base + 1);
      check("t4_timeout_latency", 64'(last_lat), 64'd17);
      bus_ready = 1'b1;
      wait_rsp(base + 2);
      check("t4_next_latency", 64'(last_lat), 64'd4);

      // Error response, then an unaffected read
      base = rsp_seen;
      en0 = en_cnt;
      bus_ready = 1'b0;
      push_cmd(1'b1, 2'd0, 32'h8, 3'd2, 3'd0, 32'h5555_AAAA, 32'h0, 1'b1, 1'b0);
      push_cmd(1'b0, 2'd1, 32'h4, 3'd2, 3'd0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      n = 0;
      while (en_cnt == en0 && n < 50) begin
         @(posedge HCLK); #1;
         n++;
      end
      repeat (4) @(posedge HCLK);
      #1;
      bus_ready = 1'b1;
      bus_resp  = 1'b1;
      wait_rsp(base + 1);
      bus_resp = 1'b0;
      wait_rsp(base + 2);

      // Reset in the middle of WAIT with commands queued
      bus_ready = 1'b0;
      push_cmd(1'b1, 2'd2, 32'h40, 3'd2, 3'd0, 32'h4040_4040, 32'h0, 1'b0, 1'b0);
      push_cmd(1'b1, 2'd2, 32'h44, 3'd2, 3'd0, 32'h4444_4444, 32'h0, 1'b0, 1'b0);
      push_cmd(1'b1, 2'd2, 32'h48, 3'd2, 3'd0, 32'h4848_4848, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge HCLK);
      #1;
      check("t6_count_before_rst", 64'(fifo_count), 64'd2);
      base = rsp_seen;
      HRST = 1'b1;
      #1;
      check("t6_rst_count", 64'(fifo_count), 64'd0);
      check("t6_rst_bus_addr", 64'(bus_addr), 64'd0);
      check("t6_rst_bus_wdata", 64'(bus_wdata), 64'd0);
      check("t6_rst_bus_write", 64'(bus_write), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      exp_q.delete();
      repeat (3) @(posedge HCLK);
      #1 HRST = 1'b0;
      repeat (5) @(posedge HCLK);
      #1;
      check("t6_no_rsp_after_rst", 64'(rsp_seen - base), 64'd0);
      check("t6_idle_after_rst", 64'(busy), 64'd0);
      bus_ready = 1'b1;
      push_cmd(1'b0, 2'd1, 32'h4, 3'd2, 3'd0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      wait_rsp(base + 1);

      repeat (3) @(posedge HCLK);
      #1;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("final_idle", 64'(busy), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
